// File: rtl/axi_lite_mem_read_slave.sv
// AXI4-Lite read responder (AR + R) in front of a word-addressed memory array.
// Fixed, parameterised access latency, R backpressure and an always-open backdoor write port.
module axi_lite_mem_read_slave #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MEM_DEPTH  = 1024,
   parameter int unsigned LATENCY    = 2
) (
   input  logic                         i_clk,
   input  logic                         i_arst,
   input  logic [ADDR_WIDTH-1:0]        i_araddr,
   input  logic                         i_arvalid,
   output logic                         o_arready,
   output logic [DATA_WIDTH-1:0]        o_rdata,
   output logic [1:0]                   o_rresp,
   output logic                         o_rvalid,
   input  logic                         i_rready,
   input  logic                         i_mem_we,
   input  logic [$clog2(MEM_DEPTH)-1:0] i_mem_waddr,
   input  logic [DATA_WIDTH-1:0]        i_mem_wdata,
   output logic                         o_busy
);

   localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
   localparam int unsigned OFF_W     = $clog2(DATA_WIDTH / 8);
   localparam int unsigned CNT_W     = 4;
   localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(DATA_WIDTH / 8);
   localparam logic [1:0]  RESP_OKAY = 2'b00;
   localparam logic [1:0]  RESP_SLV  = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        cnt_nxt;
   logic                    ar_hs;
   logic                    load_resp;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [IDX_W-1:0]        rd_idx;
   logic                    out_of_range;
   logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

   assign rd_idx       = addr_q[OFF_W +: IDX_W];
   assign out_of_range = 64'(addr_q) >= MEM_BYTES;

   // State and latency counter
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // WAIT always spends the mandatory cycle, then LATENCY more, so LATENCY=0 still passes through it
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ar_hs     = 1'b0;
      load_resp = 1'b0;
      case (state)
         IDLE: begin
            if (i_arvalid) begin
               ar_hs     = 1'b1;
               cnt_nxt   = CNT_W'(LATENCY);
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               load_resp = 1'b1;
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         RESP: begin
            if (i_rready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Captured AR address
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         addr_q <= '0;
      end else if (ar_hs) begin
         addr_q <= i_araddr;
      end
   end

   // Registered handshake/status outputs and the R payload, sampled on entry to RESP
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         o_arready <= 1'b1;
         o_rvalid  <= 1'b0;
         o_busy    <= 1'b0;
         o_rdata   <= '0;
         o_rresp   <= RESP_OKAY;
      end else begin
         o_arready <= (state_nxt == IDLE);
         o_rvalid  <= (state_nxt == RESP);
         o_busy    <= (state_nxt != IDLE);
         if (load_resp) begin
            o_rdata <= out_of_range ? '0 : mem[rd_idx];
            o_rresp <= out_of_range ? RESP_SLV : RESP_OKAY;
         end
      end
   end

   // Backdoor port: never reset, never blocked; same-edge reads see the old word
   always_ff @(posedge i_clk) begin
      if (i_mem_we) begin
         mem[i_mem_waddr] <= i_mem_wdata;
      end
   end

endmodule

// File: tb/tb_axi_lite_mem_read_slave.sv
// Scoreboard bench: expected R beats are queued when each AR is driven and checked on R handshakes.
// Instance dut runs LATENCY=2, instance dut_z runs LATENCY=0 for the backdoor collision cases.
`timescale 1ns/1ps
module tb_axi_lite_mem_read_slave;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned IW  = 10;
   localparam int unsigned LAT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          arst, arvalid, arready, rvalid, rready, mem_we, busy;
   logic [AW-1:0] araddr;
   logic [DW-1:0] rdata, mem_wdata;
   logic [1:0]    rresp;
   logic [IW-1:0] mem_waddr;

   logic          arst_z, arvalid_z, arready_z, rvalid_z, rready_z, mem_we_z, busy_z;
   logic [AW-1:0] araddr_z;
   logic [DW-1:0] rdata_z, mem_wdata_z;
   logic [1:0]    rresp_z;
   logic [IW-1:0] mem_waddr_z;

   axi_lite_mem_read_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(1024), .LATENCY(LAT)) dut (
      .i_clk(clk), .i_arst(arst), .i_araddr(araddr), .i_arvalid(arvalid), .o_arready(arready),
      .o_rdata(rdata), .o_rresp(rresp), .o_rvalid(rvalid), .i_rready(rready),
      .i_mem_we(mem_we), .i_mem_waddr(mem_waddr), .i_mem_wdata(mem_wdata), .o_busy(busy));

   axi_lite_mem_read_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(1024), .LATENCY(0)) dut_z (
      .i_clk(clk), .i_arst(arst_z), .i_araddr(araddr_z), .i_arvalid(arvalid_z), .o_arready(arready_z),
      .o_rdata(rdata_z), .o_rresp(rresp_z), .o_rvalid(rvalid_z), .i_rready(rready_z),
      .i_mem_we(mem_we_z), .i_mem_waddr(mem_waddr_z), .i_mem_wdata(mem_wdata_z), .o_busy(busy_z));

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   logic [33:0] exp_q[$];
   logic [33:0] exp_q_z[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // R-beat scoreboards
   always @(negedge clk) begin : mon_a
      logic [33:0] e;
      if (rvalid && rready) begin
         check_eq("sb_a_nonempty", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("a_rdata", 64'(rdata), 64'(e[31:0]));
            check_eq("a_rresp", 64'(rresp), 64'(e[33:32]));
         end
      end
   end

   always @(negedge clk) begin : mon_z
      logic [33:0] e;
      if (rvalid_z && rready_z) begin
         check_eq("sb_z_nonempty", 64'(exp_q_z.size() != 0), 64'(1));
         if (exp_q_z.size() != 0) begin
            e = exp_q_z.pop_front();
            check_eq("z_rdata", 64'(rdata_z), 64'(e[31:0]));
            check_eq("z_rresp", 64'(rresp_z), 64'(e[33:32]));
         end
      end
   end

   task automatic bd_write(input logic [IW-1:0] idx, input logic [DW-1:0] data);
      @(posedge clk); #1;
      mem_we = 1'b1; mem_waddr = idx; mem_wdata = data;
      @(posedge clk); #1;
      mem_we = 1'b0;
   endtask

   task automatic bd_write_z(input logic [IW-1:0] idx, input logic [DW-1:0] data);
      @(posedge clk); #1;
      mem_we_z = 1'b1; mem_waddr_z = idx; mem_wdata_z = data;
      @(posedge clk); #1;
      mem_we_z = 1'b0;
   endtask

   // Waits (bounded) until arready is seen with arvalid high; the handshake is the next rising edge
   task automatic wait_arready(input string tag);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (arready) break;
      end
      check_eq(tag, 64'(arready), 64'(1));
   endtask

   task automatic wait_arready_z(input string tag);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (arready_z) break;
      end
      check_eq(tag, 64'(arready_z), 64'(1));
   endtask

   // Issues one AR on dut; returns just after the handshake edge
   task automatic send_ar(input logic [AW-1:0] addr, input logic [33:0] exp, input bit push);
      @(posedge clk); #1;
      araddr = addr; arvalid = 1'b1;
      if (push) exp_q.push_back(exp);
      wait_arready("ar_accept");
      @(posedge clk); #1;
      arvalid = 1'b0;
   endtask

   // Cycles from the AR handshake edge to the first negedge with rvalid high
   task automatic measure_rvalid(output int lat);
      lat = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (rvalid) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin : stim
      int lat, low, t0, t1, tr, tr2;
      arst = 1'b1; arvalid = 1'b0; araddr = '0; rready = 1'b0;
      mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
      arst_z = 1'b1; arvalid_z = 1'b0; araddr_z = '0; rready_z = 1'b0;
      mem_we_z = 1'b0; mem_waddr_z = '0; mem_wdata_z = '0;

      // Preload while in reset: backdoor must be accepted there too
      bd_write(10'd5, 32'hDEAD_BEEF);
      bd_write(10'd6, 32'hCAFE_F00D);
      bd_write(10'd1023, 32'h1234_5678);
      bd_write_z(10'd7, 32'h0);
      @(posedge clk); #1;
      arst = 1'b0; arst_z = 1'b0;
      @(negedge clk);
      check_eq("rst_arready", 64'(arready), 64'(1));
      check_eq("rst_rvalid",  64'(rvalid),  64'(0));
      check_eq("rst_rdata",   64'(rdata),   64'(0));
      check_eq("rst_rresp",   64'(rresp),   64'(0));
      check_eq("rst_busy",    64'(busy),    64'(0));
      check_eq("rst_z_arready", 64'(arready_z), 64'(1));
      check_eq("rst_z_rvalid",  64'(rvalid_z),  64'(0));

      // Basic read of word 5
      rready = 1'b1;
      send_ar(32'h14, {2'b00, 32'hDEAD_BEEF}, 1'b1);
      measure_rvalid(lat);
      check_eq("basic_latency", 64'(lat), 64'(LAT + 1));
      @(negedge clk);
      check_eq("basic_arready_after", 64'(arready), 64'(1));

      // Backpressure: hold rready low for 4 cycles of rvalid
      rready = 1'b0;
      send_ar(32'h14, {2'b00, 32'hDEAD_BEEF}, 1'b1);
      measure_rvalid(lat);
      check_eq("bp_latency", 64'(lat), 64'(LAT + 1));
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         check_eq("bp_rvalid", 64'(rvalid), 64'(1));
         check_eq("bp_rdata",  64'(rdata),  64'(32'hDEAD_BEEF));
         check_eq("bp_rresp",  64'(rresp),  64'(0));
         check_eq("bp_arready", 64'(arready), 64'(0));
      end
      @(posedge clk); #1;
      rready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_eq("bp_arready_after", 64'(arready), 64'(1));
      check_eq("bp_rvalid_after",  64'(rvalid),  64'(0));

      // Out of range and last valid word
      send_ar(32'h0000_1000, {2'b10, 32'h0}, 1'b1);
      measure_rvalid(lat);
      check_eq("oor_latency", 64'(lat), 64'(LAT + 1));
      send_ar(32'h0000_0FFC, {2'b00, 32'h1234_5678}, 1'b1);
      measure_rvalid(lat);
      @(negedge clk);

      // Unaligned, back-to-back with arvalid held high
      @(posedge clk); #1;
      araddr = 32'h17; arvalid = 1'b1;
      exp_q.push_back({2'b00, 32'hDEAD_BEEF});
      wait_arready("b2b_first_accept");
      t0 = cyc + 1;
      @(posedge clk); #1;
      araddr = 32'h18;
      exp_q.push_back({2'b00, 32'hCAFE_F00D});
      low = 0; tr = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (rvalid && rready) tr = cyc + 1;
         if (arready) break;
         low++;
      end
      check_eq("b2b_arready_low", 64'(low), 64'(LAT + 2));
      check_eq("b2b_ar_to_r_1", 64'(tr - t0), 64'(LAT + 2));
      t1 = cyc + 1;
      @(posedge clk); #1;
      arvalid = 1'b0;
      tr2 = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (rvalid && rready) tr2 = cyc + 1;
         if (arready) break;
      end
      check_eq("b2b_ar_to_r_2", 64'(tr2 - t1), 64'(LAT + 2));

      // Reset during WAIT abandons the read
      send_ar(32'h14, {2'b00, 32'hDEAD_BEEF}, 1'b0);
      @(negedge clk);
      check_eq("mid_busy_wait",    64'(busy),    64'(1));
      check_eq("mid_arready_wait", 64'(arready), 64'(0));
      @(posedge clk); #1;
      arst = 1'b1;
      @(posedge clk); #1;
      arst = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_arready", 64'(arready), 64'(1));
      check_eq("mid_rst_rvalid",  64'(rvalid),  64'(0));
      check_eq("mid_rst_busy",    64'(busy),    64'(0));
      low = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (rvalid) low++;
      end
      check_eq("mid_no_stale_beat", 64'(low), 64'(0));
      send_ar(32'h14, {2'b00, 32'hDEAD_BEEF}, 1'b1);
      measure_rvalid(lat);
      check_eq("mid_reread_latency", 64'(lat), 64'(LAT + 1));
      @(negedge clk);

      // LATENCY=0: backdoor write on the edge entering RESP returns the old word
      rready_z = 1'b1;
      @(posedge clk); #1;
      araddr_z = 32'h1C; arvalid_z = 1'b1;
      exp_q_z.push_back({2'b00, 32'h0});
      wait_arready_z("z_accept_1");
      @(posedge clk); #1;
      arvalid_z = 1'b0;
      mem_we_z = 1'b1; mem_waddr_z = 10'd7; mem_wdata_z = 32'h1;
      @(negedge clk);
      check_eq("z_rvalid_wait", 64'(rvalid_z), 64'(0));
      @(posedge clk); #1;
      mem_we_z = 1'b0;
      @(negedge clk);
      check_eq("z_rvalid_resp", 64'(rvalid_z), 64'(1));
      @(negedge clk);

      // Re-read sees the new word; a write during RESP leaves the held beat alone
      rready_z = 1'b0;
      @(posedge clk); #1;
      araddr_z = 32'h1C; arvalid_z = 1'b1;
      exp_q_z.push_back({2'b00, 32'h1});
      wait_arready_z("z_accept_2");
      @(posedge clk); #1;
      arvalid_z = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("z2_rvalid", 64'(rvalid_z), 64'(1));
      bd_write_z(10'd7, 32'h2);
      @(negedge clk);
      check_eq("z2_rdata_held", 64'(rdata_z), 64'(32'h1));
      @(posedge clk); #1;
      rready_z = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_eq("z2_arready_after", 64'(arready_z), 64'(1));

      repeat (4) @(negedge clk);
      check_eq("sb_a_drained", 64'(exp_q.size()),   64'(0));
      check_eq("sb_z_drained", 64'(exp_q_z.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
